ddisplay_capture: RTL and testbench

//  Reader side of the 8-digit multiplexed 7-segment interface driven by dynamic_display.

---
 rtl/ddisplay_capture_if.sv | 38 +++
 rtl/ddisplay_capture.sv | 176 +++++++++++++++++
 tb/tb_ddisplay_capture.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ddisplay_capture_if.sv
// ----------------------------------------------------------------------------
// ddisplay_capture_if
//   Bundles the multiplexed 7-segment pins sampled by ddisplay_capture and the
//   decoded frame outputs it produces.
//   Signals:
//     an[7:0]         digit enables, active-low (driven by the display side)
//     seg[7:0]        segments, active-low, seg[7]=dp (driven by the display side)
//     data_out[31:0]  last complete frame
//     valid           1-cycle pulse when data_out updates
//     err             held with data_out: frame contained an undecodable digit
//     digit_mask[7:0] digits captured so far in the current frame
//   With DDISPLAY_BCD2BIN_EN defined, also carries bin_out[26:0], bin_valid,
//   bin_err from the BCD-to-binary converter.
//   Modports: master = display/bench side, slave = capture monitor side.
// ----------------------------------------------------------------------------
interface ddisplay_capture_if;
   logic [7:0]  an;
   logic [7:0]  seg;
   logic [31:0] data_out;
   logic        valid;
   logic        err;
   logic [7:0]  digit_mask;
`ifdef DDISPLAY_BCD2BIN_EN
   logic [26:0] bin_out;
   logic        bin_valid;
   logic        bin_err;

   modport master (output an, seg,
                   input  data_out, valid, err, digit_mask, bin_out, bin_valid, bin_err);
   modport slave  (input  an, seg,
                   output data_out, valid, err, digit_mask, bin_out, bin_valid, bin_err);
`else
   modport master (output an, seg,
                   input  data_out, valid, err, digit_mask);
   modport slave  (input  an, seg,
                   output data_out, valid, err, digit_mask);
`endif
endinterface

// File: rtl/ddisplay_capture.sv
// ----------------------------------------------------------------------------
// ddisplay_capture
//   Reader side of an 8-digit multiplexed 7-segment display. Samples an/seg,
//   waits for STABLE_CYCLES identical samples per digit dwell, decodes the
//   segment pattern to a hex nibble and reassembles a 32-bit frame.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     dd     ddisplay_capture_if.slave (an, seg in; data_out, valid, err,
//            digit_mask out; bin_out, bin_valid, bin_err when enabled)
//   Parameters:
//     STABLE_CYCLES  identical samples required to accept a digit (>=2)
//     CNT_W          stability counter width, STABLE_CYCLES < 2**CNT_W
//   Optional feature macro: DDISPLAY_BCD2BIN_EN adds a sequential BCD-to-binary
//   converter fed by every completed frame.
// ----------------------------------------------------------------------------
module ddisplay_capture #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   ddisplay_capture_if.slave dd
);

   logic [7:0]       an_q, seg_q, an_p_q, seg_p_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accd_q, accd_d;
   logic [31:0]      shadow_q, shadow_d;
   logic [7:0]       mask_q, mask_d;
   logic             eacc_q, eacc_d;
   logic [31:0]      data_q;
   logic             valid_q, err_q;

   logic [7:0]       sel;
   logic             onehot, same, hit, complete, accd_live;
   logic [3:0]       nib;
   logic             bad;

   assign sel      = ~an_q;
   assign onehot   = (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
   assign same     = {an_q, seg_q} == {an_p_q, seg_p_q};
   assign complete = (mask_q == 8'hFF);

   always_comb begin
      nib = 4'h0;
      bad = 1'b0;
      case (seg_q[6:0])
         7'h40: nib = 4'h0;
         7'h79: nib = 4'h1;
         7'h24: nib = 4'h2;
         7'h30: nib = 4'h3;
         7'h19: nib = 4'h4;
         7'h12: nib = 4'h5;
         7'h02: nib = 4'h6;
         7'h78: nib = 4'h7;
         7'h00: nib = 4'h8;
         7'h10: nib = 4'h9;
         7'h08: nib = 4'hA;
         7'h03: nib = 4'hB;
         7'h46: nib = 4'hC;
         7'h21: nib = 4'hD;
         7'h06: nib = 4'hE;
         7'h0E: nib = 4'hF;
         default: bad = 1'b1;
      endcase
   end

   always_comb begin
      cnt_d    = '0;
      if (onehot && same)
         cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      // one acceptance per dwell; a new an_q value starts a new dwell
      accd_live = accd_q && (an_q == an_p_q);
      hit       = onehot && !accd_live && (cnt_d == CNT_W'(STABLE_CYCLES - 1));
      accd_d    = accd_live || hit;

      // frame completion clears first; a same-cycle acceptance starts the next frame
      mask_d   = complete ? 8'h00 : mask_q;
      eacc_d   = complete ? 1'b0  : eacc_q;
      shadow_d = shadow_q;
      if (hit) begin
         mask_d = mask_d | sel;
         eacc_d = eacc_d | bad;
         for (int unsigned i = 0; i < 8; i++)
            if (sel[i]) shadow_d[4*i +: 4] = nib;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q     <= '0;
         seg_q    <= '0;
         an_p_q   <= '0;
         seg_p_q  <= '0;
         cnt_q    <= '0;
         accd_q   <= 1'b0;
         shadow_q <= '0;
         mask_q   <= '0;
         eacc_q   <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         an_q     <= dd.an;
         seg_q    <= dd.seg;
         an_p_q   <= an_q;
         seg_p_q  <= seg_q;
         cnt_q    <= cnt_d;
         accd_q   <= accd_d;
         shadow_q <= shadow_d;
         mask_q   <= mask_d;
         eacc_q   <= eacc_d;
         valid_q  <= complete;
         if (complete) begin
            data_q <= shadow_q;
            err_q  <= eacc_q;
         end
      end
   end

   assign dd.data_out   = data_q;
   assign dd.valid      = valid_q;
   assign dd.err        = err_q;
   assign dd.digit_mask = mask_q;

`ifdef DDISPLAY_BCD2BIN_EN
   logic [31:0] bcd_q;
   logic [26:0] bacc_q, bin_q, bnext;
   logic [2:0]  step_q;
   logic        busy_q, bvalid_q, berr_acc_q, berr_q;
   logic [3:0]  bdig;

   // MS digit first: shift the loaded frame left one nibble per step
   assign bdig  = bcd_q[31:28];
   assign bnext = (bacc_q << 3) + (bacc_q << 1) + 27'(bdig);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_q      <= '0;
         bacc_q     <= '0;
         bin_q      <= '0;
         step_q     <= '0;
         busy_q     <= 1'b0;
         bvalid_q   <= 1'b0;
         berr_acc_q <= 1'b0;
         berr_q     <= 1'b0;
      end else begin
         bvalid_q <= 1'b0;
         if (complete) begin
            bcd_q      <= shadow_q;
            bacc_q     <= '0;
            step_q     <= '0;
            busy_q     <= 1'b1;
            berr_acc_q <= 1'b0;
         end else if (busy_q) begin
            bacc_q     <= bnext;
            bcd_q      <= {bcd_q[27:0], 4'h0};
            step_q     <= step_q + 3'd1;
            berr_acc_q <= berr_acc_q | (bdig > 4'd9);
            if (step_q == 3'd7) begin
               busy_q   <= 1'b0;
               bvalid_q <= 1'b1;
               bin_q    <= bnext;
               berr_q   <= berr_acc_q | (bdig > 4'd9);
            end
         end
      end
   end

   assign dd.bin_out   = bin_q;
   assign dd.bin_valid = bvalid_q;
   assign dd.bin_err   = berr_q;
`endif

endmodule

// File: tb/tb_ddisplay_capture.sv
module tb_ddisplay_capture;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ddisplay_capture_if dd();

   ddisplay_capture #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dd    (dd.slave)
   );

   int unsigned total = 0;
   int unsigned nbad  = 0;

   int unsigned vcount = 0;
   logic [31:0] vdata;
   logic        verr;
   always @(negedge clk) begin
      if (dd.valid === 1'b1) begin
         vcount++;
         vdata = dd.data_out;
         verr  = dd.err;
      end
   end

`ifdef DDISPLAY_BCD2BIN_EN
   int unsigned bcount = 0;
   logic [26:0] bdata;
   logic        berr;
   always @(negedge clk) begin
      if (dd.bin_valid === 1'b1) begin
         bcount++;
         bdata = dd.bin_out;
         berr  = dd.bin_err;
      end
   end
`endif

   typedef struct {
      logic [31:0] nib;
      logic [7:0]  badm;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;
   vec_t vt[6];

   function automatic logic [6:0] enc(input logic [3:0] n);
      case (n)
         4'h0: enc = 7'h40; 4'h1: enc = 7'h79; 4'h2: enc = 7'h24; 4'h3: enc = 7'h30;
         4'h4: enc = 7'h19; 4'h5: enc = 7'h12; 4'h6: enc = 7'h02; 4'h7: enc = 7'h78;
         4'h8: enc = 7'h00; 4'h9: enc = 7'h10; 4'hA: enc = 7'h08; 4'hB: enc = 7'h03;
         4'hC: enc = 7'h46; 4'hD: enc = 7'h21; 4'hE: enc = 7'h06; default: enc = 7'h0E;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_digit(input int unsigned i, input logic [6:0] pat, input int unsigned dwell);
      dd.an  = ~(8'd1 << i);
      dd.seg = {1'b1, pat};
      repeat (dwell) @(posedge clk);
      #1;
      dd.an  = 8'hFF;
      dd.seg = 8'hFF;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [31:0] nib, input logic [7:0] badm);
      for (int unsigned i = 0; i < 8; i++)
         send_digit(i, badm[i] ? 7'h7F : enc(nib[4*i +: 4]), 6);
   endtask

   // bounded wait for one valid pulse, then a few idle cycles to catch extras
   task automatic wait_frame(input int unsigned v0, input string name);
      int unsigned n = 0;
      while (vcount == v0 && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk(name, vcount - v0, 32'd1);
   endtask

   initial begin
      int unsigned v0;
`ifdef DDISPLAY_BCD2BIN_EN
      int unsigned b0;
`endif
      vt[0] = '{32'h00FF00FF, 8'h00, 32'h00FF00FF, 1'b0};
      vt[1] = '{32'h00001234, 8'h00, 32'h00001234, 1'b0};
      vt[2] = '{32'hDEADBEEF, 8'h00, 32'hDEADBEEF, 1'b0};
      vt[3] = '{32'hCAFEF00D, 8'h01, 32'hCAFEF000, 1'b1};
      vt[4] = '{32'h89ABCDEF, 8'h00, 32'h89ABCDEF, 1'b0};
      vt[5] = '{32'h11111111, 8'h40, 32'h10111111, 1'b1};

      rst_n  = 1'b0;
      dd.an  = 8'hFF;
      dd.seg = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", dd.data_out, 32'h0);
      chk("rst_valid", {31'h0, dd.valid}, 32'h0);
      chk("rst_err", {31'h0, dd.err}, 32'h0);
      chk("rst_mask", {24'h0, dd.digit_mask}, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      for (int k = 0; k < 6; k++) begin
         v0 = vcount;
`ifdef DDISPLAY_BCD2BIN_EN
         b0 = bcount;
`endif
         send_frame(vt[k].nib, vt[k].badm);
         wait_frame(v0, "vec_valid_count");
         chk("vec_data", vdata, vt[k].exp_data);
         chk("vec_err", {31'h0, verr}, {31'h0, vt[k].exp_err});
         chk("vec_mask_clear", {24'h0, dd.digit_mask}, 32'h0);
`ifdef DDISPLAY_BCD2BIN_EN
         if (k == 1) begin
            for (int n = 0; n < 20 && bcount == b0; n++) begin
               @(posedge clk);
               #1;
            end
            chk("bin_count", bcount - b0, 32'd1);
            chk("bin_out", {5'h0, bdata}, 32'd1234);
            chk("bin_err", {31'h0, berr}, 32'h0);
         end
`endif
      end

      // reset mid-frame: partial frame discarded, outputs cleared
      send_frame(32'h00000005, 8'h00);
      v0 = vcount;
      for (int unsigned i = 0; i < 5; i++) send_digit(i, enc(4'h3), 6);
      chk("partial_mask", {24'h0, dd.digit_mask}, 32'h0000001F);
      rst_n = 1'b0;
      #2;
      chk("midrst_data", dd.data_out, 32'h0);
      chk("midrst_err", {31'h0, dd.err}, 32'h0);
      chk("midrst_mask", {24'h0, dd.digit_mask}, 32'h0);
      chk("midrst_valid", {31'h0, dd.valid}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      v0 = vcount;
      send_frame(32'h87654321, 8'h00);
      wait_frame(v0, "postrst_valid_count");
      chk("postrst_data", vdata, 32'h87654321);

      // glitch inside a '5' dwell on digit 3 shorter than the stability window
      v0 = vcount;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i == 3) begin
            dd.an  = 8'hF7;
            dd.seg = {1'b1, enc(4'h5)};
            repeat (2) @(posedge clk);
            #1;
            dd.seg = {1'b1, 7'h79};
            repeat (3) @(posedge clk);
            #1;
            send_digit(3, enc(4'h5), 6);
         end else begin
            send_digit(i, enc(4'h0), 6);
         end
      end
      wait_frame(v0, "glitch_valid_count");
      chk("glitch_data", vdata, 32'h00005000);

      // multi-hot an held: no acceptance, mask frozen, no valid
      v0 = vcount;
      for (int unsigned i = 0; i < 3; i++) send_digit(i, enc(4'(i)), 6);
      dd.an  = 8'hF0;
      dd.seg = {1'b1, enc(4'h8)};
      repeat (50) @(posedge clk);
      #1;
      chk("multihot_mask", {24'h0, dd.digit_mask}, 32'h00000007);
      chk("multihot_novalid", vcount - v0, 32'd0);
      dd.an  = 8'hFF;
      dd.seg = 8'hFF;
      @(posedge clk);
      #1;
      for (int unsigned i = 3; i < 8; i++) send_digit(i, enc(4'(i)), 6);
      wait_frame(v0, "multihot_valid_count");
      chk("multihot_data", vdata, 32'h76543210);

      // digit 0 captured twice in one frame: later value wins, no error
      v0 = vcount;
      send_digit(0, enc(4'h1), 6);
      send_digit(0, enc(4'h9), 6);
      for (int unsigned i = 1; i < 8; i++) send_digit(i, enc(4'hA), 6);
      wait_frame(v0, "overwrite_valid_count");
      chk("overwrite_data", vdata, 32'hAAAAAAA9);
      chk("overwrite_err", {31'h0, verr}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, nbad);
      $finish;
   end

endmodule
